// File: rtl/cpu_io_host.sv
// Host-side endpoint for the CPU I/O ports. Two first-word-fall-through FIFOs:
// host->CPU (input path) and CPU->host (output path, with sticky drop flag).
module cpu_io_host #(
    parameter int DATA_W    = 16,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            host_tx_data,
    input  logic                         host_tx_valid,
    output logic                         host_tx_ready,
    output logic [DATA_W-1:0]            host_rx_data,
    output logic                         host_rx_valid,
    input  logic                         host_rx_ready,
    output logic [DATA_W-1:0]            cpu_in_port,
    output logic                         cpu_input_valid,
    input  logic                         cpu_input_ready,
    input  logic [DATA_W-1:0]            cpu_out_port,
    input  logic                         cpu_output_valid,
    output logic [$clog2(IN_DEPTH):0]    in_level,
    output logic [$clog2(OUT_DEPTH):0]   out_level,
    output logic                         overflow,
    input  logic                         overflow_clr
);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);

    logic [DATA_W-1:0] in_mem  [IN_DEPTH];
    logic [DATA_W-1:0] out_mem [OUT_DEPTH];

    logic [IAW:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [OAW:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic         overflow_q, overflow_d;

    logic in_full, in_empty, in_push, in_pop;
    logic out_full, out_empty, out_push, out_pop, out_drop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign in_full   = (in_wr_q[IAW-1:0] == in_rd_q[IAW-1:0]) && (in_wr_q[IAW] != in_rd_q[IAW]);
    assign in_empty  = (in_wr_q == in_rd_q);
    assign out_full  = (out_wr_q[OAW-1:0] == out_rd_q[OAW-1:0]) && (out_wr_q[OAW] != out_rd_q[OAW]);
    assign out_empty = (out_wr_q == out_rd_q);

    assign host_tx_ready   = !in_full;
    assign cpu_input_valid = !in_empty;
    assign host_rx_valid   = !out_empty;

    assign in_push  = host_tx_valid && !in_full;
    assign in_pop   = !in_empty && cpu_input_ready;
    assign out_pop  = !out_empty && host_rx_ready;
    // A full output FIFO still accepts a word when the host frees the head slot this cycle.
    assign out_push = cpu_output_valid && (!out_full || out_pop);
    assign out_drop = cpu_output_valid && out_full && !out_pop;

    always_comb begin
        in_wr_d    = in_push  ? in_wr_q  + 1'b1 : in_wr_q;
        in_rd_d    = in_pop   ? in_rd_q  + 1'b1 : in_rd_q;
        out_wr_d   = out_push ? out_wr_q + 1'b1 : out_wr_q;
        out_rd_d   = out_pop  ? out_rd_q + 1'b1 : out_rd_q;
        overflow_d = overflow_q;
        if (out_drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_wr_q    <= '0;
            in_rd_q    <= '0;
            out_wr_q   <= '0;
            out_rd_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            in_wr_q    <= in_wr_d;
            in_rd_q    <= in_rd_d;
            out_wr_q   <= out_wr_d;
            out_rd_q   <= out_rd_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is never reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && in_push) begin
            in_mem[in_wr_q[IAW-1:0]] <= host_tx_data;
        end
        if (!rst && out_push) begin
            out_mem[out_wr_q[OAW-1:0]] <= cpu_out_port;
        end
    end

    assign cpu_in_port  = in_mem[in_rd_q[IAW-1:0]];
    assign host_rx_data = out_mem[out_rd_q[OAW-1:0]];
    assign in_level     = in_wr_q - in_rd_q;
    assign out_level    = out_wr_q - out_rd_q;
    assign overflow     = overflow_q;

endmodule
